// File: rtl/signal_debouncer_pkg.sv
// -----------------------------------------------------------------------------
// signal_debouncer_pkg
// Shared types and constants for the signal debouncer and its synchronizer.
//   deb_state_e          : debounce FSM states (STABLE, CONFIRM)
//   DEB_SYNC_STAGES_DEF  : default synchronizer depth
//   DEB_CYCLES_DEF       : default number of confirmation cycles
//   deb_cnt_width()      : width of the confirmation counter for a cycle count
// -----------------------------------------------------------------------------
package signal_debouncer_pkg;

    typedef enum logic {
        STABLE  = 1'b0,
        CONFIRM = 1'b1
    } deb_state_e;

    localparam int DEB_SYNC_STAGES_DEF = 2;
    localparam int DEB_CYCLES_DEF      = 4;

    // Counter must be able to represent DEBOUNCE_CYCLES itself.
    function automatic int deb_cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/signal_debouncer_sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
// Multi-flop synchronizer for a single asynchronous level input. Reusable for
// any pin that has no timing relation to clk.
// Parameters:
//   STAGES      : number of flops in the chain (2..4)
//   RESET_VALUE : level loaded into every flop while rst_n is low
// Ports:
//   clk   in  : sampling clock
//   rst_n in  : asynchronous active-low reset
//   din   in  : asynchronous input level
//   dout  out : synchronized level (last flop of the chain)
// -----------------------------------------------------------------------------
module sync_chain #(
    parameter int   STAGES      = 2,
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    // chain_q[0] is the metastability-exposed flop; only the last stage leaves.
    always_comb begin
        chain_d = {chain_q[STAGES-2:0], din};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= {STAGES{RESET_VALUE}};
        end else begin
            chain_q <= chain_d;
        end
    end

    assign dout = chain_q[STAGES-1];

endmodule

// File: rtl/signal_debouncer.sv
// -----------------------------------------------------------------------------
// signal_debouncer
// Conditions an asynchronous, possibly bouncing raw input into a clean,
// synchronous level. raw_in is synchronized through a flop chain, then a new
// level is accepted only after it has held for DEBOUNCE_CYCLES consecutive
// cycles.
// Optional feature macro: SIGNAL_DEBOUNCER_EDGE_PULSE_EN
//   defined   : rise_pulse / fall_pulse are registered one-cycle edge pulses
//   undefined : rise_pulse / fall_pulse tied to 0, no edge flops
// Parameters:
//   SYNC_STAGES     : synchronizer depth (2..4)
//   DEBOUNCE_CYCLES : confirmation length in cycles (1..65535)
//   RESET_VALUE     : level of synchronizer and in_signal during/after reset
// Ports:
//   clk        in  : clock, rising edge
//   rst_n      in  : asynchronous active-low reset
//   raw_in     in  : asynchronous raw level
//   in_signal  out : debounced level
//   pending    out : high while a candidate change is being confirmed
//   rise_pulse out : one cycle pulse on in_signal 0->1 (optional)
//   fall_pulse out : one cycle pulse on in_signal 1->0 (optional)
// -----------------------------------------------------------------------------
module signal_debouncer
    import signal_debouncer_pkg::*;
#(
    parameter int   SYNC_STAGES     = DEB_SYNC_STAGES_DEF,
    parameter int   DEBOUNCE_CYCLES = DEB_CYCLES_DEF,
    parameter logic RESET_VALUE     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_in,
    output logic in_signal,
    output logic pending,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int              CNT_W    = deb_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             sync_q;
    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_signal_q, in_signal_d;
    logic             pending_q, pending_d;

    // Synchronizer stage
    sync_chain #(
        .STAGES      (SYNC_STAGES),
        .RESET_VALUE (RESET_VALUE)
    ) u_sync_chain (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (raw_in),
        .dout  (sync_q)
    );

    // Debounce stage: next-state logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_signal_d = in_signal_q;

        case (state_q)
            STABLE: begin
                cnt_d = '0;
                if (sync_q != in_signal_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        // A single matching sample is already sufficient.
                        in_signal_d = sync_q;
                    end else begin
                        state_d = CONFIRM;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            CONFIRM: begin
                if (sync_q == in_signal_q) begin
                    // Bounced back before confirmation: drop the candidate.
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    in_signal_d = sync_q;
                    cnt_d       = '0;
                    state_d     = STABLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase

        pending_d = (state_d == CONFIRM);
    end

`ifdef SIGNAL_DEBOUNCER_EDGE_PULSE_EN
    logic rise_pulse_q, rise_pulse_d;
    logic fall_pulse_q, fall_pulse_d;

    // Pulses coincide with the first cycle of the new in_signal level.
    always_comb begin
        rise_pulse_d =  in_signal_d & ~in_signal_q;
        fall_pulse_d = ~in_signal_d &  in_signal_q;
    end
`endif

    // Debounce stage: registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= STABLE;
            cnt_q        <= '0;
            in_signal_q  <= RESET_VALUE;
            pending_q    <= 1'b0;
`ifdef SIGNAL_DEBOUNCER_EDGE_PULSE_EN
            rise_pulse_q <= 1'b0;
            fall_pulse_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            in_signal_q  <= in_signal_d;
            pending_q    <= pending_d;
`ifdef SIGNAL_DEBOUNCER_EDGE_PULSE_EN
            rise_pulse_q <= rise_pulse_d;
            fall_pulse_q <= fall_pulse_d;
`endif
        end
    end

    assign in_signal = in_signal_q;
    assign pending   = pending_q;

`ifdef SIGNAL_DEBOUNCER_EDGE_PULSE_EN
    assign rise_pulse = rise_pulse_q;
    assign fall_pulse = fall_pulse_q;
`else
    assign rise_pulse = 1'b0;
    assign fall_pulse = 1'b0;
`endif

endmodule
